// File: rtl/frv_asi_seq_pkg.sv
// Shared uop codes, uop-class decode and sequencer state encoding for the
// frv_asi sequencer.
package frv_asi_seq_pkg;

   localparam int OP = 6;

   // uop class lives in uop[OP:OP-1]
   localparam logic [1:0] ASI_MISC = 2'b00;
   localparam logic [1:0] ASI_AES  = 2'b01;
   localparam logic [1:0] ASI_SHA2 = 2'b10;
   localparam logic [1:0] ASI_SHA3 = 2'b11;

   // For AES uops, bit 2 selects MixColumns (1) vs SubBytes (0)
   localparam logic [OP:0] ASI_AESSUB_ENC = 7'b01_00000;
   localparam logic [OP:0] ASI_AESSUB_DEC = 7'b01_00001;
   localparam logic [OP:0] ASI_AESMIX_ENC = 7'b01_00100;
   localparam logic [OP:0] ASI_AESMIX_DEC = 7'b01_00101;
   localparam logic [OP:0] ASI_SHA256_S0  = 7'b10_00000;
   localparam logic [OP:0] ASI_SHA256_S1  = 7'b10_00001;
   localparam logic [OP:0] ASI_SHA3_XY    = 7'b11_00000;

   typedef enum logic [1:0] {
      ASI_SEQ_IDLE  = 2'd0,
      ASI_SEQ_ISSUE = 2'd1,
      ASI_SEQ_FLUSH = 2'd2,
      ASI_SEQ_HOLD  = 2'd3
   } asi_seq_state_t;

   function automatic logic is_aes(input logic [OP:0] uop);
      return uop[OP:OP-1] == ASI_AES;
   endfunction

endpackage

// File: rtl/frv_asi_seq.sv
// Sequencer between execute and frv_asi: issues one op, captures the result or
// a timeout error, and pulses AES sub-unit flushes on kill/timeout/CSR request.
module frv_asi_seq
   import frv_asi_seq_pkg::*;
#(
   parameter int XLEN    = 32,
   parameter int TIMEOUT = 16
) (
   input  logic              g_clk,
   input  logic              g_reset,

   input  logic              s_valid,
   output logic              s_ready,
   input  logic [OP:0]       s_uop,
   input  logic [XLEN-1:0]   s_rs1,
   input  logic [XLEN-1:0]   s_rs2,
   input  logic [1:0]        s_shamt,
   input  logic              s_kill,

   output logic              r_valid,
   input  logic              r_ready,
   output logic [XLEN-1:0]   r_data,
   output logic              r_err,

   input  logic              f_req,
   input  logic [1:0]        f_sel,
   input  logic [31:0]       f_data,
   output logic              f_ack,

   output logic              asi_valid,
   input  logic              asi_ready,
   output logic [OP:0]       asi_uop,
   output logic [XLEN-1:0]   asi_rs1,
   output logic [XLEN-1:0]   asi_rs2,
   output logic [1:0]        asi_shamt,
   input  logic [XLEN-1:0]   asi_result,

   output logic              asi_flush_aessub,
   output logic              asi_flush_aesmix,
   output logic [31:0]       asi_flush_data
);

   localparam int         XL       = XLEN - 1;
   localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

   asi_seq_state_t state, state_d;

   logic [OP:0]  uop_q;
   logic [XL:0]  rs1_q, rs2_q;
   logic [1:0]   shamt_q;
   logic [7:0]   cnt;
   logic [XL:0]  res_q;
   logic         err_q;
   logic         fl_sub_q, fl_mix_q, fl_ext_q, to_hold_q;
   logic [31:0]  fl_data_q;

   logic accept, ext_flush, int_flush, cap_res, cap_to, cnt_inc, set_to_hold;

   always_comb begin
      state_d     = state;
      accept      = 1'b0;
      ext_flush   = 1'b0;
      int_flush   = 1'b0;
      cap_res     = 1'b0;
      cap_to      = 1'b0;
      cnt_inc     = 1'b0;
      set_to_hold = 1'b0;
      case (state)
         ASI_SEQ_IDLE: begin
            if (f_req) begin
               ext_flush = 1'b1;
               state_d   = ASI_SEQ_FLUSH;
            end else if (s_valid) begin
               accept  = 1'b1;
               state_d = ASI_SEQ_ISSUE;
            end
         end
         ASI_SEQ_ISSUE: begin
            // kill outranks a same-cycle result; the result is discarded
            if (s_kill) begin
               if (is_aes(uop_q)) begin
                  int_flush = 1'b1;
                  state_d   = ASI_SEQ_FLUSH;
               end else begin
                  state_d = ASI_SEQ_IDLE;
               end
            end else if (asi_ready) begin
               cap_res = 1'b1;
               state_d = ASI_SEQ_HOLD;
            end else if (cnt == CNT_LAST) begin
               cap_to = 1'b1;
               if (is_aes(uop_q)) begin
                  int_flush   = 1'b1;
                  set_to_hold = 1'b1;
                  state_d     = ASI_SEQ_FLUSH;
               end else begin
                  state_d = ASI_SEQ_HOLD;
               end
            end else begin
               cnt_inc = 1'b1;
            end
         end
         ASI_SEQ_FLUSH: state_d = to_hold_q ? ASI_SEQ_HOLD : ASI_SEQ_IDLE;
         ASI_SEQ_HOLD: begin
            if (r_ready || s_kill) state_d = ASI_SEQ_IDLE;
         end
         default: state_d = ASI_SEQ_IDLE;
      endcase
   end

   always_ff @(posedge g_clk) begin
      if (g_reset) begin
         state     <= ASI_SEQ_IDLE;
         uop_q     <= '0;
         rs1_q     <= '0;
         rs2_q     <= '0;
         shamt_q   <= '0;
         cnt       <= '0;
         res_q     <= '0;
         err_q     <= 1'b0;
         fl_sub_q  <= 1'b0;
         fl_mix_q  <= 1'b0;
         fl_ext_q  <= 1'b0;
         fl_data_q <= '0;
         to_hold_q <= 1'b0;
      end else begin
         state <= state_d;
         if (accept) begin
            uop_q   <= s_uop;
            rs1_q   <= s_rs1;
            rs2_q   <= s_rs2;
            shamt_q <= s_shamt;
            cnt     <= '0;
         end
         if (cnt_inc && cnt != '1) cnt <= cnt + 8'd1;
         if (cap_res) begin
            res_q <= asi_result;
            err_q <= 1'b0;
         end
         if (cap_to) begin
            res_q <= '0;
            err_q <= 1'b1;
         end
         if (ext_flush) begin
            fl_sub_q  <= f_sel[0];
            fl_mix_q  <= f_sel[1];
            fl_data_q <= f_data;
            fl_ext_q  <= 1'b1;
         end
         if (int_flush) begin
            fl_sub_q  <= ~uop_q[2];
            fl_mix_q  <= uop_q[2];
            fl_data_q <= '0;
            fl_ext_q  <= 1'b0;
         end
         if (set_to_hold)                to_hold_q <= 1'b1;
         else if (state == ASI_SEQ_FLUSH) to_hold_q <= 1'b0;
      end
   end

   assign s_ready          = (state == ASI_SEQ_IDLE) && !f_req;
   assign asi_valid        = (state == ASI_SEQ_ISSUE);
   assign asi_uop          = uop_q;
   assign asi_rs1          = rs1_q;
   assign asi_rs2          = rs2_q;
   assign asi_shamt        = shamt_q;
   assign asi_flush_aessub = (state == ASI_SEQ_FLUSH) && fl_sub_q;
   assign asi_flush_aesmix = (state == ASI_SEQ_FLUSH) && fl_mix_q;
   assign asi_flush_data   = (state == ASI_SEQ_FLUSH) ? fl_data_q : '0;
   assign f_ack            = (state == ASI_SEQ_FLUSH) && fl_ext_q;
   assign r_valid          = (state == ASI_SEQ_HOLD);
   assign r_data           = res_q;
   assign r_err            = err_q;

endmodule

// File: tb/tb_frv_asi_seq.sv
// Bench for frv_asi_seq: hand sequences, a table of directed ops and random ops
// checked against a transaction-level outcome model; frv_asi is a stub.
module tb_frv_asi_seq;
   import frv_asi_seq_pkg::*;

   localparam int T = 4;

   logic        g_clk = 1'b0;
   logic        g_reset;
   logic        s_valid, s_ready, s_kill;
   logic [OP:0] s_uop;
   logic [31:0] s_rs1, s_rs2;
   logic [1:0]  s_shamt;
   logic        r_valid, r_ready, r_err;
   logic [31:0] r_data;
   logic        f_req, f_ack;
   logic [1:0]  f_sel;
   logic [31:0] f_data;
   logic        asi_valid, asi_ready;
   logic [OP:0] asi_uop;
   logic [31:0] asi_rs1, asi_rs2, asi_result;
   logic [1:0]  asi_shamt;
   logic        asi_flush_aessub, asi_flush_aesmix;
   logic [31:0] asi_flush_data;

   always #5 g_clk = ~g_clk;

   frv_asi_seq #(.XLEN(32), .TIMEOUT(T)) dut (
      .g_clk(g_clk), .g_reset(g_reset),
      .s_valid(s_valid), .s_ready(s_ready), .s_uop(s_uop), .s_rs1(s_rs1),
      .s_rs2(s_rs2), .s_shamt(s_shamt), .s_kill(s_kill),
      .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data), .r_err(r_err),
      .f_req(f_req), .f_sel(f_sel), .f_data(f_data), .f_ack(f_ack),
      .asi_valid(asi_valid), .asi_ready(asi_ready), .asi_uop(asi_uop),
      .asi_rs1(asi_rs1), .asi_rs2(asi_rs2), .asi_shamt(asi_shamt),
      .asi_result(asi_result),
      .asi_flush_aessub(asi_flush_aessub), .asi_flush_aesmix(asi_flush_aesmix),
      .asi_flush_data(asi_flush_data)
   );

   int checks = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // stand-in for frv_asi's datapath
   function automatic logic [31:0] stub_res(input logic [31:0] a, input logic [31:0] b);
      return a ^ {b[15:0], b[31:16]} ^ 32'h5A5A_0001;
   endfunction

   // ready_at/kill_at: ISSUE cycle index (0-based) where the input is high, -1 = never.
   // exp_flush: 0 none, 1 sub, 2 mix. exp_lat: cycle index of first r_valid, -1 = none.
   typedef struct {
      logic [OP:0] uop;
      int          ready_at;
      int          kill_at;
      int          rwait;
      bit          hold_kill;
      int          exp_issue;
      int          exp_flush;
      int          exp_lat;
      bit          exp_err;
   } vec_t;

   // Outcome of one op: the earliest of kill, ready, or the last allowed cycle ends
   // ISSUE, with kill outranking ready and ready outranking the timeout.
   function automatic vec_t model(input vec_t v);
      vec_t r = v;
      bit aes = (v.uop[OP:OP-1] == ASI_AES);
      int fl  = aes ? (v.uop[2] ? 2 : 1) : 0;
      int k_end = T - 1;
      if (v.ready_at >= 0 && v.ready_at < k_end) k_end = v.ready_at;
      if (v.kill_at  >= 0 && v.kill_at  < k_end) k_end = v.kill_at;
      r.exp_issue = k_end + 1;
      if (v.kill_at == k_end) begin
         r.exp_flush = fl; r.exp_lat = -1; r.exp_err = 1'b0;
      end else if (v.ready_at == k_end) begin
         r.exp_flush = 0; r.exp_lat = k_end + 1; r.exp_err = 1'b0;
      end else begin
         r.exp_flush = fl; r.exp_lat = T + (aes ? 1 : 0); r.exp_err = 1'b1;
      end
      return r;
   endfunction

   // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle.
   task automatic run_op(input vec_t v, input string tag);
      logic [31:0] rs1, rs2, d0;
      logic [1:0]  sh, fsel;
      logic [31:0] fdat;
      logic        e0;
      bit          stable;
      int n_av, n_fl, n_ack, first, k_end, c_max;
      rs1 = $urandom; rs2 = $urandom; sh = 2'($urandom);
      k_end = v.exp_issue - 1;
      c_max = (v.exp_lat >= 0) ? v.exp_lat + v.rwait + 1 : v.exp_issue + ((v.exp_flush != 0) ? 1 : 0);
      n_av = 0; n_fl = 0; n_ack = 0; first = -1; fsel = '0; fdat = '0; d0 = '0; e0 = 1'b0; stable = 1'b1;

      chk({tag, "/s_ready_idle"}, 64'(s_ready), 64'(1));
      s_valid = 1'b1; s_uop = v.uop; s_rs1 = rs1; s_rs2 = rs2; s_shamt = sh;
      @(negedge g_clk);
      s_valid = 1'b0; s_uop = 7'($urandom); s_rs1 = $urandom; s_rs2 = $urandom; s_shamt = 2'($urandom);

      for (int c = 0; c <= c_max; c++) begin
         if (asi_valid) n_av++;
         if (c == 0) begin
            chk({tag, "/asi_uop"}, 64'(asi_uop), 64'(v.uop));
            chk({tag, "/asi_rs1"}, 64'(asi_rs1), 64'(rs1));
            chk({tag, "/asi_rs2"}, 64'({asi_shamt, asi_rs2}), 64'({sh, rs2}));
         end
         if (asi_flush_aessub || asi_flush_aesmix) begin
            n_fl++; fsel = {asi_flush_aesmix, asi_flush_aessub}; fdat = asi_flush_data;
         end
         if (f_ack) n_ack++;
         if (r_valid) begin
            if (first < 0) begin
               first = c; d0 = r_data; e0 = r_err;
            end else if (r_data !== d0 || r_err !== e0) begin
               stable = 1'b0;
            end
         end
         if (c == c_max) begin
            chk({tag, "/end_r_valid"}, 64'(r_valid), 64'(0));
            chk({tag, "/end_s_ready"}, 64'(s_ready), 64'(1));
         end else begin
            s_kill    = ((c <= k_end) && c == v.kill_at) ||
                        (v.exp_lat >= 0 && v.hold_kill && c == v.exp_lat + v.rwait);
            r_ready   = (v.exp_lat >= 0 && !v.hold_kill && c == v.exp_lat + v.rwait);
            asi_ready = (c <= k_end) && c == v.ready_at;
            asi_result = asi_ready ? stub_res(rs1, rs2) : $urandom;
            @(negedge g_clk);
         end
      end
      s_kill = 1'b0; r_ready = 1'b0; asi_ready = 1'b0;

      chk({tag, "/issue_cycles"}, 64'(n_av), 64'(v.exp_issue));
      chk({tag, "/flush_cycles"}, 64'(n_fl), 64'((v.exp_flush != 0) ? 1 : 0));
      if (v.exp_flush != 0) begin
         chk({tag, "/flush_sel"}, 64'(fsel), 64'(v.exp_flush));
         chk({tag, "/flush_data"}, 64'(fdat), 64'(0));
      end
      chk({tag, "/f_ack_cycles"}, 64'(n_ack), 64'(0));
      chk({tag, "/r_valid_cycle"}, 64'(first), 64'(v.exp_lat));
      if (v.exp_lat >= 0) begin
         chk({tag, "/r_data"}, 64'(d0), 64'(v.exp_err ? 32'h0 : stub_res(rs1, rs2)));
         chk({tag, "/r_err"}, 64'(e0), 64'(v.exp_err));
         chk({tag, "/r_stable"}, 64'(stable), 64'(1));
      end
   endtask

   task automatic to_hold(input logic [OP:0] uop, input logic [31:0] res);
      s_valid = 1'b1; s_uop = uop; s_rs1 = $urandom; s_rs2 = $urandom;
      @(negedge g_clk);
      s_valid = 1'b0; asi_ready = 1'b1; asi_result = res;
      @(negedge g_clk);
      asi_ready = 1'b0;
   endtask

   vec_t tbl[10];
   vec_t v;
   logic [OP:0] codes[7];

   initial begin
      g_reset = 1'b1; s_valid = 1'b0; s_uop = '0; s_rs1 = '0; s_rs2 = '0; s_shamt = '0;
      s_kill = 1'b0; r_ready = 1'b0; f_req = 1'b0; f_sel = '0; f_data = '0;
      asi_ready = 1'b0; asi_result = '0;
      repeat (2) @(negedge g_clk);
      g_reset = 1'b0;

      chk("rst/s_ready", 64'(s_ready), 64'(1));
      chk("rst/r_valid_err", 64'({r_valid, r_err}), 64'(0));
      chk("rst/r_data", 64'(r_data), 64'(0));
      chk("rst/asi_valid_ack", 64'({asi_valid, f_ack, asi_flush_aessub, asi_flush_aesmix}), 64'(0));
      chk("rst/asi_ops", 64'({asi_uop, asi_shamt, asi_rs1}), 64'(0));
      chk("rst/asi_rs2_fd", 64'({asi_rs2, asi_flush_data}), 64'(0));

      // flush request collides with an op in IDLE: flush first, then the op
      f_req = 1'b1; f_sel = 2'b11; f_data = 32'hDEAD_BEEF;
      s_valid = 1'b1; s_uop = ASI_SHA256_S0; s_rs1 = 32'h0000_0001; s_rs2 = '0;
      #1 chk("frq/s_ready_idle", 64'(s_ready), 64'(0));
      @(negedge g_clk);
      chk("frq/pulse", 64'({f_ack, asi_flush_aesmix, asi_flush_aessub, asi_valid}), 64'(4'b1110));
      chk("frq/data", 64'(asi_flush_data), 64'(32'hDEAD_BEEF));
      chk("frq/s_ready_flush", 64'(s_ready), 64'(0));
      f_req = 1'b0;
      @(negedge g_clk);
      chk("frq/after", 64'({f_ack, asi_flush_aesmix, asi_flush_aessub, s_ready}), 64'(4'b0001));
      @(negedge g_clk);
      s_valid = 1'b0;
      chk("frq/accepted", 64'({asi_valid, asi_uop}), 64'({1'b1, ASI_SHA256_S0}));
      asi_ready = 1'b1; asi_result = 32'h0200_4000;
      @(negedge g_clk);
      asi_ready = 1'b0;
      chk("frq/result", 64'({r_valid, r_err, r_data}), 64'({2'b10, 32'h0200_4000}));
      r_ready = 1'b1;
      @(negedge g_clk);
      r_ready = 1'b0;
      chk("frq/released", 64'(r_valid), 64'(0));

      // flush request during HOLD waits for IDLE
      to_hold(ASI_SHA3_XY, 32'hCAFE_0001);
      f_req = 1'b1; f_sel = 2'b01; f_data = 32'h0BAD_F00D;
      @(negedge g_clk);
      chk("fhold/held", 64'({r_valid, f_ack, asi_flush_aessub}), 64'(3'b100));
      r_ready = 1'b1;
      @(negedge g_clk);
      r_ready = 1'b0;
      chk("fhold/idle", 64'({r_valid, s_ready, f_ack}), 64'(0));
      @(negedge g_clk);
      f_req = 1'b0;
      chk("fhold/pulse", 64'({f_ack, asi_flush_aesmix, asi_flush_aessub, asi_flush_data}), 64'({3'b101, 32'h0BAD_F00D}));
      @(negedge g_clk);

      // reset while holding a result
      to_hold(ASI_SHA256_S1, 32'h1234_5678);
      chk("rhold/held", 64'({r_valid, r_data}), 64'({1'b1, 32'h1234_5678}));
      g_reset = 1'b1;
      @(negedge g_clk);
      g_reset = 1'b0;
      chk("rhold/r", 64'({r_valid, r_err, r_data}), 64'(0));
      chk("rhold/asi", 64'({asi_valid, f_ack, asi_flush_aessub, asi_flush_aesmix, asi_uop, asi_rs1}), 64'(0));
      chk("rhold/s_ready", 64'(s_ready), 64'(1));

      tbl[0] = '{ASI_SHA256_S0,  0, -1, 0, 0, 1, 0,  1, 0};
      tbl[1] = '{ASI_SHA3_XY,   -1, -1, 5, 0, 4, 0,  4, 1};
      tbl[2] = '{ASI_AESMIX_ENC,-1, -1, 1, 0, 4, 2,  5, 1};
      tbl[3] = '{ASI_AESSUB_ENC, 0,  0, 0, 0, 1, 1, -1, 0};
      tbl[4] = '{ASI_SHA256_S1,  3, -1, 0, 0, 4, 0,  4, 0};
      tbl[5] = '{ASI_SHA3_XY,   -1,  2, 0, 0, 3, 0, -1, 0};
      tbl[6] = '{ASI_AESSUB_DEC, 2, -1, 2, 1, 3, 0,  3, 0};
      tbl[7] = '{ASI_AESSUB_ENC,-1, -1, 0, 1, 4, 1,  5, 1};
      tbl[8] = '{ASI_AESMIX_DEC,-1,  3, 0, 0, 4, 2, -1, 0};
      tbl[9] = '{ASI_AESMIX_ENC, 1,  3, 0, 0, 2, 0,  2, 0};
      for (int i = 0; i < 10; i++) run_op(tbl[i], $sformatf("tbl%0d", i));

      codes = '{ASI_AESSUB_ENC, ASI_AESSUB_DEC, ASI_AESMIX_ENC, ASI_AESMIX_DEC,
                ASI_SHA256_S0, ASI_SHA256_S1, ASI_SHA3_XY};
      for (int i = 0; i < 60; i++) begin
         v.uop       = codes[$urandom_range(0, 6)];
         v.ready_at  = int'($urandom_range(0, T + 1)) - 1;
         v.kill_at   = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, T)) : -1;
         v.rwait     = int'($urandom_range(0, 3));
         v.hold_kill = ($urandom_range(0, 3) == 0);
         v = model(v);
         run_op(v, $sformatf("rnd%0d", i));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
